// File: rtl/pipelined_barrel_shifter_if.sv
// Valid/ready stream bundle for the pipelined barrel shifter.
// Carries the input beat, the result beat and the busy flag.
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 8
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Log2(WIDTH)-stage barrel shifter with a global stall enable.
// Define BARREL_ROTATE_EN to make mode 11 rotate left instead of shift left.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 8
) (
    input logic                      clk,
    input logic                      rst_n,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] st_data  [SHW];
    logic [SHW-1:0]   st_amt   [SHW];
    logic [1:0]       st_mode  [SHW];
    logic [SHW-1:0]   st_vld;

    logic [WIDTH-1:0] src_data [SHW];
    logic [SHW-1:0]   src_amt  [SHW];
    logic [1:0]       src_mode [SHW];
    logic [WIDTH-1:0] nxt_data [SHW];

    logic adv;
    logic acc;

    assign adv          = bus.out_ready || !bus.out_valid;
    assign bus.in_ready = adv && rst_n;
    assign acc          = bus.in_valid && bus.in_ready;

    function automatic logic [WIDTH-1:0] shift_by(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       m,
        input int               s
    );
        logic [WIDTH-1:0] r;
        unique case (m)
            2'b01:   r = d >> s;
            2'b10:   r = WIDTH'($signed(d) >>> s);
`ifdef BARREL_ROTATE_EN
            2'b11:   r = (d << s) | (d >> (WIDTH - s));
`endif
            default: r = d << s;
        endcase
        return r;
    endfunction

    // Stage k applies the 2^k step; stage 0 is fed straight from the input.
    always_comb begin
        src_data[0] = bus.in_data;
        src_amt[0]  = bus.in_amt;
        src_mode[0] = bus.in_mode;
        for (int k = 1; k < SHW; k++) begin
            src_data[k] = st_data[k-1];
            src_amt[k]  = st_amt[k-1];
            src_mode[k] = st_mode[k-1];
        end
        for (int k = 0; k < SHW; k++) begin
            nxt_data[k] = src_data[k];
            if (src_amt[k][k])
                nxt_data[k] = shift_by(src_data[k], src_mode[k], 1 << k);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_vld <= '0;
            for (int k = 0; k < SHW; k++) begin
                st_data[k] <= '0;
                st_amt[k]  <= '0;
                st_mode[k] <= '0;
            end
        end else if (adv) begin
            st_vld[0] <= acc;
            for (int k = 1; k < SHW; k++)
                st_vld[k] <= st_vld[k-1];
            for (int k = 0; k < SHW; k++) begin
                st_data[k] <= nxt_data[k];
                st_amt[k]  <= src_amt[k];
                st_mode[k] <= src_mode[k];
            end
        end
    end

    assign bus.out_valid = st_vld[SHW-1];
    assign bus.out_data  = st_vld[SHW-1] ? st_data[SHW-1] : '0;
    assign bus.busy      = |st_vld;
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter, WIDTH=8.
// Covers all modes, latency, stall hold, and mid-flight reset.
module tb_pipelined_barrel_shifter;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;

    pipelined_barrel_shifter_if #(.WIDTH(8)) bus ();

    pipelined_barrel_shifter #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] a;
        logic [1:0] m;
        logic [7:0] e;
    } vec_t;

`ifdef BARREL_ROTATE_EN
    localparam logic [7:0] ROT_B5 = 8'hAD;
    localparam logic [7:0] ROT_80 = 8'h40;
`else
    localparam logic [7:0] ROT_B5 = 8'hA8;
    localparam logic [7:0] ROT_80 = 8'h00;
`endif

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        @(negedge clk);
        bus.in_data   = v.d;
        bus.in_amt    = v.a;
        bus.in_mode   = v.m;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk($sformatf("vec%0d_in_ready", idx), 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 10) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk($sformatf("vec%0d_latency", idx), 32'(n), 32'd3);
        chk($sformatf("vec%0d_data", idx), 32'(bus.out_data), 32'(v.e));
    endtask

    vec_t vt [15];
    logic [7:0] sdat [8];
    logic [7:0] sexp [8];

    initial begin
        int sent;
        int rcv;
        int cyc;
        logic [7:0] held;

        vt[0]  = '{8'hB5, 3'd3, 2'b00, 8'hA8};
        vt[1]  = '{8'hB5, 3'd3, 2'b01, 8'h16};
        vt[2]  = '{8'hB5, 3'd3, 2'b10, 8'hF6};
        vt[3]  = '{8'hB5, 3'd3, 2'b11, ROT_B5};
        vt[4]  = '{8'h5A, 3'd0, 2'b00, 8'h5A};
        vt[5]  = '{8'h5A, 3'd0, 2'b01, 8'h5A};
        vt[6]  = '{8'hA5, 3'd0, 2'b10, 8'hA5};
        vt[7]  = '{8'hA5, 3'd0, 2'b11, 8'hA5};
        vt[8]  = '{8'h80, 3'd7, 2'b00, 8'h00};
        vt[9]  = '{8'h80, 3'd7, 2'b01, 8'h01};
        vt[10] = '{8'h80, 3'd7, 2'b10, 8'hFF};
        vt[11] = '{8'h80, 3'd7, 2'b11, ROT_80};
        vt[12] = '{8'h81, 3'd1, 2'b10, 8'hC0};
        vt[13] = '{8'h81, 3'd4, 2'b01, 8'h08};
        vt[14] = '{8'h0F, 3'd4, 2'b00, 8'hF0};

        sdat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        sexp = '{8'h22, 8'h44, 8'h66, 8'h88, 8'hAA, 8'hCC, 8'hEE, 8'h10};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.in_mode   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 15; i++)
            run_vec(vt[i], i);

        // Eight back-to-back beats, downstream stalled in cycles 2..6
        sent = 0;
        rcv  = 0;
        held = '0;
        bus.in_amt  = 3'd1;
        bus.in_mode = 2'b00;
        for (cyc = 0; cyc < 40 && !(rcv == 8 && cyc > 20); cyc++) begin
            @(negedge clk);
            bus.out_ready = !(cyc >= 2 && cyc <= 6);
            bus.in_valid  = (sent < 8);
            bus.in_data   = (sent < 8) ? sdat[sent] : 8'h00;
            #1;
            if (!bus.out_valid && bus.out_data !== 8'h00)
                chk("strm_idle_data", 32'(bus.out_data), 32'd0);
            if (cyc >= 3 && cyc <= 6) begin
                chk($sformatf("strm_stall_in_ready_c%0d", cyc),
                    32'(bus.in_ready), 32'd0);
                if (cyc == 3)
                    held = bus.out_data;
                else
                    chk($sformatf("strm_hold_c%0d", cyc),
                        32'(bus.out_data), 32'(held));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (rcv < 8)
                    chk($sformatf("strm_beat%0d", rcv),
                        32'(bus.out_data), 32'(sexp[rcv]));
                else
                    chk("strm_duplicate", 32'(rcv), 32'd8);
                rcv++;
            end
            if (bus.in_valid && bus.in_ready)
                sent++;
        end
        chk("strm_held_first", 32'(held), 32'h22);
        chk("strm_count", 32'(rcv), 32'd8);

        // Mid-flight reset discards the beats still in the pipe
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = sdat[i];
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready_low", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_out_data", 32'(bus.out_data), 32'd0);
        rcv = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid || bus.busy)
                rcv++;
        end
        chk("mrst_no_stale", 32'(rcv), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
